// File: rtl/host_link_scheduler.sv
// Host link lane sequencer: staggered serializer release, per-lane request-cadence watchdog
// with whole-link restart on timing faults, and gap-limited aux word insertion on the last lane.
module host_link_scheduler #(
   parameter int unsigned NUM_LANES   = 2,
   parameter int unsigned WORD_CYCLES = 30,
   parameter int unsigned START_DELAY = 5,
   parameter int unsigned AUX_MIN_GAP = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [NUM_LANES-1:0] i_data_read,
   input  logic                 i_aux_valid,
   output logic [NUM_LANES-1:0] o_lane_reset,
   output logic [NUM_LANES-1:0] o_sample,
   output logic                 o_aux_sel,
   output logic                 o_aux_ack,
   output logic                 o_locked,
   output logic                 o_fault,
   output logic [7:0]           o_restart_count
);

   localparam int unsigned STAGGER = WORD_CYCLES / NUM_LANES;
   localparam int unsigned START_MAX = START_DELAY + (NUM_LANES - 1) * STAGGER;
   localparam int unsigned CNT_W = $clog2(START_MAX + 2);
   localparam int unsigned WD_W = $clog2(WORD_CYCLES + 1);
   localparam int unsigned GAP_W = $clog2(AUX_MIN_GAP + 1);
   localparam int unsigned LAST = NUM_LANES - 1;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(START_MAX);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WORD_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(AUX_MIN_GAP);

   typedef enum logic [1:0] {StStartup, StRun, StFault} state_e;

   state_e               state_q;
   logic [CNT_W-1:0]     start_cnt_q, start_cnt_d;
   logic [NUM_LANES-1:0] lane_reset_q, lane_reset_d;
   logic [WD_W-1:0]      wd_q [NUM_LANES];
   logic [NUM_LANES-1:0] first_seen_q;
   logic [NUM_LANES-1:0] lane_fault;
   logic [GAP_W-1:0]     gap_q;
   logic                 locked_q;
   logic                 fault_q;
   logic [7:0]           restart_q;
   logic                 fault;
   logic                 sample_last;
   logic                 grant;

   // Cadence check: a released lane must request exactly on its last watchdog count.
   always_comb begin
      lane_fault = '0;
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
         if (!lane_reset_q[k] && state_q != StFault) begin
            if (wd_q[k] == WD_LAST) begin
               lane_fault[k] = !i_data_read[k];
            end else begin
               lane_fault[k] = i_data_read[k] & first_seen_q[k];
            end
         end
      end
   end

   assign fault = |lane_fault;

   always_comb begin
      start_cnt_d = start_cnt_q;
      if (fault) begin
         start_cnt_d = '0;
      end else begin
         case (state_q)
            StStartup: begin
               if (start_cnt_q != CNT_MAX) start_cnt_d = start_cnt_q + CNT_W'(1);
            end
            StRun: start_cnt_d = start_cnt_q;
            default: start_cnt_d = '0;
         endcase
      end
      // Lane resets follow the next counter value so they come out of a flop.
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
         lane_reset_d[k] = fault || (start_cnt_d < CNT_W'(START_DELAY + k * STAGGER));
      end
   end

   assign sample_last = i_data_read[LAST] & ~lane_reset_q[LAST];
   // A same-cycle fault drops lock, so it also cancels the aux grant.
   assign grant = sample_last & i_aux_valid & locked_q & (gap_q == GAP_MAX) & ~fault;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= StStartup;
         start_cnt_q  <= '0;
         lane_reset_q <= '1;
         first_seen_q <= '0;
         for (int unsigned k = 0; k < NUM_LANES; k++) wd_q[k] <= '0;
         locked_q     <= 1'b0;
         fault_q      <= 1'b0;
         restart_q    <= 8'd0;
         gap_q        <= '0;
      end else begin
         start_cnt_q  <= start_cnt_d;
         lane_reset_q <= lane_reset_d;

         for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (fault || lane_reset_q[k]) begin
               wd_q[k]         <= '0;
               first_seen_q[k] <= 1'b0;
            end else if (i_data_read[k]) begin
               wd_q[k]         <= '0;
               first_seen_q[k] <= 1'b1;
            end else begin
               wd_q[k] <= wd_q[k] + WD_W'(1);
            end
         end

         if (fault) begin
            state_q  <= StFault;
            fault_q  <= 1'b1;
            locked_q <= 1'b0;
            gap_q    <= '0;
            if (restart_q != 8'hFF) restart_q <= restart_q + 8'd1;
         end else begin
            case (state_q)
               StStartup: begin
                  if (start_cnt_q == CNT_MAX) state_q <= StRun;
               end
               StRun: begin
                  if (&first_seen_q) locked_q <= 1'b1;
               end
               default: begin
                  state_q <= StStartup;
                  gap_q   <= '0;
               end
            endcase
            if (sample_last) begin
               if (grant) begin
                  gap_q <= '0;
               end else if (gap_q != GAP_MAX) begin
                  gap_q <= gap_q + GAP_W'(1);
               end
            end
         end
      end
   end

   assign o_lane_reset    = lane_reset_q;
   assign o_sample        = i_data_read & ~lane_reset_q;
   assign o_aux_sel       = grant;
   assign o_aux_ack       = grant;
   assign o_locked        = locked_q;
   assign o_fault         = fault_q;
   assign o_restart_count = restart_q;

endmodule

// File: tb/tb_host_link_scheduler.sv
// Bench for host_link_scheduler: nominal serializer stimulus with directed faults, a timestamp
// model checked every cycle, and literal checks at hand-computed cycles.
module tb_host_link_scheduler;

   localparam int unsigned NL   = 2;
   localparam int unsigned WC   = 30;
   localparam int unsigned SD   = 5;
   localparam int unsigned GAP  = 8;
   localparam int unsigned STG  = WC / NL;
   localparam int unsigned MAXC = SD + (NL - 1) * STG;

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b1;
   logic [NL-1:0] i_data_read = '0;
   logic          i_aux_valid = 1'b0;
   logic [NL-1:0] o_lane_reset;
   logic [NL-1:0] o_sample;
   logic          o_aux_sel;
   logic          o_aux_ack;
   logic          o_locked;
   logic          o_fault;
   logic [7:0]    o_restart_count;

   host_link_scheduler #(
      .NUM_LANES  (NL),
      .WORD_CYCLES(WC),
      .START_DELAY(SD),
      .AUX_MIN_GAP(GAP)
   ) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_data_read    (i_data_read),
      .i_aux_valid    (i_aux_valid),
      .o_lane_reset   (o_lane_reset),
      .o_sample       (o_sample),
      .o_aux_sel      (o_aux_sel),
      .o_aux_ack      (o_aux_ack),
      .o_locked       (o_locked),
      .o_fault        (o_fault),
      .o_restart_count(o_restart_count)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int thr(input int k);
      return SD + k * STG;
   endfunction

   // Reference model: lane timing kept as absolute cycle timestamps.
   int            mc = 0;
   bit            m_valid = 0;
   int            m_start;
   bit            m_in_fault;
   int            ref_t [NL];
   int            seen_t [NL];
   int            m_gap;
   bit            m_fault;
   int            m_rc;

   always @(negedge i_clk) begin
      logic [NL-1:0] exp_lr;
      logic [NL-1:0] exp_samp;
      bit            fault_now;
      bit            all_seen;
      int            max_seen;
      bit            exp_locked;
      bit            grant;
      int            age;
      if (m_valid) begin
         fault_now = 0;
         all_seen  = 1;
         max_seen  = 0;
         for (int k = 0; k < NL; k++) begin
            exp_lr[k] = m_in_fault || ((mc - m_start) < thr(k));
            exp_samp[k] = i_data_read[k] & ~exp_lr[k];
            if (!exp_lr[k]) begin
               age = mc - ref_t[k];
               if (!i_data_read[k] && age == WC - 1) fault_now = 1;
               if (i_data_read[k] && seen_t[k] >= 0 && age != WC - 1) fault_now = 1;
            end
            if (seen_t[k] < 0) all_seen = 0;
            else if (seen_t[k] > max_seen) max_seen = seen_t[k];
         end
         exp_locked = !m_in_fault && all_seen && (mc >= max_seen + 2) && (mc >= m_start + MAXC + 2);
         grant = exp_samp[NL-1] && i_aux_valid && exp_locked && (m_gap == GAP) && !fault_now;

         check("lane_reset", 32'(o_lane_reset), 32'(exp_lr));
         check("sample", 32'(o_sample), 32'(exp_samp));
         check("aux_sel", 32'(o_aux_sel), 32'(grant));
         check("aux_ack", 32'(o_aux_ack), 32'(grant));
         check("locked", 32'(o_locked), 32'(exp_locked));
         check("fault", 32'(o_fault), 32'(m_fault));
         check("restart_count", 32'(o_restart_count), 32'(m_rc));

         if (!i_reset) begin
            if (fault_now) begin
               m_in_fault = 1;
               m_fault    = 1;
               m_rc       = (m_rc < 255) ? m_rc + 1 : 255;
               m_gap      = 0;
               m_start    = mc + 2;
               for (int k = 0; k < NL; k++) begin
                  seen_t[k] = -1;
                  ref_t[k]  = m_start + thr(k);
               end
            end else begin
               m_in_fault = 0;
               for (int k = 0; k < NL; k++) begin
                  if (exp_samp[k]) begin
                     ref_t[k] = mc + 1;
                     if (seen_t[k] < 0) seen_t[k] = mc;
                  end
               end
               if (exp_samp[NL-1]) m_gap = grant ? 0 : ((m_gap < GAP) ? m_gap + 1 : GAP);
            end
         end
      end
      if (i_reset) begin
         m_valid    = 1;
         m_start    = mc + 1;
         m_in_fault = 0;
         m_gap      = 0;
         m_fault    = 0;
         m_rc       = 0;
         for (int k = 0; k < NL; k++) begin
            seen_t[k] = -1;
            ref_t[k]  = m_start + thr(k);
         end
      end
      mc++;
   end

   // Serializer stimulus: requests every WC cycles, first one WC-1 cycles after release.
   int            rel = 0;
   int            ser_age [NL];
   bit            mute [NL];
   bit            drop [NL];
   logic [NL-1:0] extra = '0;
   int            n_ack = 0;
   int            n_ack_unlocked = 0;
   int            first_ack = -1;
   int            n_samp0 = 0;
   int            n_samp1 = 0;

   task automatic cycle();
      logic [NL-1:0] rq;
      bit            nominal;
      @(posedge i_clk);
      #1;
      rel++;
      for (int k = 0; k < NL; k++) begin
         rq[k] = 1'b0;
         if (o_lane_reset[k] !== 1'b0) begin
            ser_age[k] = 0;
         end else begin
            nominal = (ser_age[k] == WC - 1);
            ser_age[k] = nominal ? 0 : ser_age[k] + 1;
            rq[k] = nominal && !mute[k] && !drop[k];
            if (nominal && drop[k]) drop[k] = 0;
         end
      end
      i_data_read = rq | extra;
      extra = '0;
      #1;
      if (o_aux_ack === 1'b1) begin
         n_ack++;
         if (first_ack < 0) first_ack = rel;
         if (o_locked !== 1'b1) n_ack_unlocked++;
      end
      n_samp0 += int'(o_sample[0]);
      n_samp1 += int'(o_sample[1]);
   endtask

   task automatic run_to(input int n);
      while (rel < n) cycle();
   endtask

   task automatic clear_counts();
      n_ack = 0;
      n_ack_unlocked = 0;
      first_ack = -1;
      n_samp0 = 0;
      n_samp1 = 0;
   endtask

   initial begin
      for (int k = 0; k < NL; k++) begin
         ser_age[k] = 0;
         mute[k] = 0;
         drop[k] = 0;
      end
      i_aux_valid = 1'b1;
      cycle();
      cycle();
      i_reset = 1'b0;
      rel = 0;
      clear_counts();

      // Startup stagger and lock.
      run_to(4);   check("lr_rel4", 32'(o_lane_reset), 32'h3);
      run_to(5);   check("lr_rel5", 32'(o_lane_reset), 32'h2);
      run_to(19);  check("lr_rel19", 32'(o_lane_reset), 32'h2);
      run_to(20);  check("lr_rel20", 32'(o_lane_reset), 32'h0);
      run_to(50);  check("locked_rel50", 32'(o_locked), 32'h0);
      run_to(51);  check("locked_rel51", 32'(o_locked), 32'h1);
      check("fault_rel51", 32'(o_fault), 32'h0);

      // Aux held from reset: grants on lane1 samples 9, 18, 27.
      run_to(900);
      check("first_ack", 32'(first_ack), 32'd289);
      check("ack_count", 32'(n_ack), 32'd3);
      check("ack_unlocked", 32'(n_ack_unlocked), 32'd0);
      check("samp0_900", 32'(n_samp0), 32'd29);
      check("samp1_900", 32'(n_samp1), 32'd29);

      // Steady run without aux.
      i_aux_valid = 1'b0;
      clear_counts();
      run_to(1900);
      check("ack_none", 32'(n_ack), 32'd0);
      check("samp0_1900", 32'(n_samp0), 32'd34);
      check("samp1_1900", 32'(n_samp1), 32'd33);
      check("rc_steady", 32'(o_restart_count), 32'd0);

      // Late fault: lane0 request at 1924 dropped.
      drop[0] = 1;
      run_to(1925);
      check("lr_fault", 32'(o_lane_reset), 32'h3);
      check("fault_late", 32'(o_fault), 32'h1);
      check("rc_late", 32'(o_restart_count), 32'd1);
      check("locked_fault", 32'(o_locked), 32'h0);
      run_to(1930); check("lr_restart_1930", 32'(o_lane_reset), 32'h3);
      run_to(1931); check("lr_restart_1931", 32'(o_lane_reset), 32'h2);
      run_to(1976); check("relock_1976", 32'(o_locked), 32'h0);
      run_to(1977); check("relock_1977", 32'(o_locked), 32'h1);

      // Early fault: extra lane1 request 10 cycles after the one at 1975.
      run_to(1984);
      extra = 2'b10;
      run_to(1986);
      check("rc_early", 32'(o_restart_count), 32'd2);
      check("lr_early", 32'(o_lane_reset), 32'h3);

      // Muted lane0 forces a late fault every 36 cycles: 300 more restarts.
      mute[0] = 1;
      run_to(1987 + 300 * 36);
      check("rc_sat", 32'(o_restart_count), 32'd255);
      check("fault_sat", 32'(o_fault), 32'h1);
      check("lr_sat", 32'(o_lane_reset), 32'h3);
      mute[0] = 0;

      // Reset mid-STARTUP clears sticky fault and count.
      run_to(12799);
      check("lr_mid_startup", 32'(o_lane_reset), 32'h2);
      i_reset = 1'b1;
      cycle();
      i_reset = 1'b0;
      #1;
      check("rst_lr", 32'(o_lane_reset), 32'h3);
      check("rst_fault", 32'(o_fault), 32'h0);
      check("rst_rc", 32'(o_restart_count), 32'd0);
      check("rst_locked", 32'(o_locked), 32'h0);

      // Reset mid-RUN with aux pending, then first grant again after nine lane1 samples.
      i_aux_valid = 1'b1;
      clear_counts();
      run_to(13000);
      check("run_locked", 32'(o_locked), 32'h1);
      check("run_no_ack", 32'(n_ack), 32'd0);
      i_reset = 1'b1;
      cycle();
      i_reset = 1'b0;
      #1;
      check("rst2_locked", 32'(o_locked), 32'h0);
      check("rst2_ack", 32'(o_aux_ack), 32'h0);
      check("rst2_lr", 32'(o_lane_reset), 32'h3);
      clear_counts();
      run_to(13001 + 300);
      check("first_ack_after_rst", 32'(first_ack), 32'd13290);
      check("ack_unlocked_end", 32'(n_ack_unlocked), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL timeout: simulation did not complete, got rel=%0d", rel);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
